bitflip_scrub_sensor: RTL and testbench
=======================================

Name: bitflip_scrub_sensor

Overview:
Radiation bit-flip monitor. It holds a parametrised array of sentinel words initialised to a known pattern. A state machine scans the array continuously, counts flipped bits per word and rewrites (scrubs) any corrupted word. It sits in userLogic beside the other sensors and reports a sticky error flag, saturating flip/event counters and a per-event record. A test-injection port lets the bench create flips deterministically.

Parameters:
WORDS, 16, number of sentinel words (>=2)
WIDTH, 8, bits per sentinel word (>=1)
PATTERN, 8'hA5, expected value of even words; odd words expect ~PATTERN (WIDTH bits)
CNT_W, 16, width of flip_count and event_count
SCAN_GAP, 4, idle cycles between the end of one scan and the start of the next (0 allowed)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = scanning runs; 0 = FSM holds in IDLE after the current word completes
clear  in  1  synchronous clear of counters and sticky error
inject_valid  in  1  test: toggle one sentinel bit this cycle
inject_word  in  IW=max(1,$clog2(WORDS))  test: word index
inject_bit  in  max(1,$clog2(WIDTH))  test: bit index
error  out  1  sticky; set by any detected flip
flip_count  out  CNT_W  total flipped bits detected, saturating
event_count  out  CNT_W  number of corrupted words scrubbed, saturating
event_valid  out  1  one-cycle pulse per scrubbed word
event_word  out  IW  index of scrubbed word, valid with event_valid
event_bits  out  $clog2(WIDTH+1)  popcount of that word's error, valid with event_valid
scan_done  out  1  one-cycle pulse on completion of a full pass

Behaviour:
- Reset (async assert, sync release): every sentinel word is loaded with its expected value; all counters are 0; error, event_valid and scan_done are 0; event_word and event_bits are 0; FSM goes to IDLE; the word index and gap counter are 0.
- expected(i) = PATTERN if i is even, ~PATTERN if i is odd.
- FSM states: IDLE, CHECK, SCRUB, GAP.
  - IDLE: if enable, go to CHECK with idx=0.
  - CHECK: diff = word[idx] ^ expected(idx).
    - If diff != 0, capture popcount(diff) and go to SCRUB.
    - Otherwise, advance (see below).
  - SCRUB (one cycle): write expected(idx) into word[idx]. Pulse event_valid with event_word=idx and event_bits=captured popcount. Add popcount to flip_count, add 1 to event_count, set error. Then advance.
  - Advance: if idx==WORDS-1, pulse scan_done, set idx=0 and go to GAP (or straight to CHECK if SCAN_GAP==0 and enable). Otherwise, increment idx and go to CHECK if enable, else IDLE.
  - GAP: count SCAN_GAP cycles, then go to CHECK if enable, else IDLE.
- Timing: a clean pass takes WORDS cycles of CHECK; each corrupted word adds 1 cycle. event_valid is asserted in the SCRUB cycle, i.e. 1 cycle after the CHECK of that word.
- Saturation: flip_count and event_count stick at 2^CNT_W-1. The addition is computed at CNT_W+1 bits and clamped.
- clear: zeroes the counters and error next edge. It does not touch the array or the FSM. If clear coincides with a SCRUB increment, clear wins (result 0). The event_valid pulse is still emitted.
- Injection: toggles word[inject_word][inject_bit] at the next edge. Out-of-range indices are ignored. If injection targets the word being written in SCRUB that same cycle, the scrub write wins and the injection is dropped. Injection into a word already checked this pass is detected on the next pass.
- Multiple injections into the same word before its CHECK accumulate. Toggling the same bit twice restores it, so no event is raised.
- Deasserting enable mid-scan: the current CHECK/SCRUB completes, then the FSM enters IDLE with idx retained. Re-enable resumes at idx.
- Reset mid-operation: the array is restored immediately and all state is cleared. No event pulse is emitted.
- Sentinel array must not be optimised away: implement it as registers with the keep attribute.

Test Plan:
- Reset, enable=1, no injection, 3 passes (WORDS=16, SCAN_GAP=4) -> scan_done every 20 cycles; no event_valid; error=0; counts 0.
- Inject word 5 bit 3 while idx<5 -> one event_valid with event_word=5, event_bits=1; flip_count=1; event_count=1; error=1; word 5 reads back 8'h5A.
- Inject bits 0, 2 and 7 of word 2 before its check -> event_bits=3, flip_count=3; that pass takes 17 CHECK/SCRUB cycles.
- Force flip_count to 0xFFFE via repeated injections (or CNT_W=4), then inject a 3-bit error -> flip_count saturates at max; event_count increments normally.
- Assert clear in the same cycle as a SCRUB -> counters=0 and error=0 afterwards; event_valid still pulses once.
- Inject word 9, drop enable mid-scan at idx=4, hold for 10 cycles, re-enable -> no scan_done while idle; scan resumes at idx 4; the event for word 9 occurs later; assert rst_n=0 mid-pass and verify all outputs are 0 immediately.

Source files
------------

// File: rtl/bitflip_scrub_sensor.sv
// Radiation bit-flip monitor: scans a register array of sentinel words, counts
// flipped bits, scrubs corrupted words and reports saturating statistics.
module bitflip_scrub_sensor #(
    parameter int unsigned      WORDS    = 16,
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] PATTERN  = WIDTH'(8'hA5),
    parameter int unsigned      CNT_W    = 16,
    parameter int unsigned      SCAN_GAP = 4,
    localparam int unsigned     IW       = (WORDS > 1) ? $clog2(WORDS) : 1,
    localparam int unsigned     BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    localparam int unsigned     PW       = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    input  logic             inject_valid,
    input  logic [IW-1:0]    inject_word,
    input  logic [BW-1:0]    inject_bit,
    output logic             error,
    output logic [CNT_W-1:0] flip_count,
    output logic [CNT_W-1:0] event_count,
    output logic             event_valid,
    output logic [IW-1:0]    event_word,
    output logic [PW-1:0]    event_bits,
    output logic             scan_done
);

    localparam int unsigned GW = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_SCRUB, S_GAP} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IW-1:0]       r_idx;
    logic [IW-1:0]       w_idx_nxt;
    logic [GW-1:0]       r_gap;
    logic [GW-1:0]       w_gap_nxt;
    logic                w_advance;
    logic                w_done_nxt;
    logic [WIDTH-1:0]    w_diff;
    logic [PW-1:0]       w_pop;
    logic [WIDTH-1:0]    w_inj_mask;
    logic [CNT_W:0]      w_flip_sum;
    logic [CNT_W:0]      w_evt_sum;
    logic [CNT_W-1:0]    w_flip_sat;
    logic [CNT_W-1:0]    w_evt_sat;

    (* keep *) logic [WIDTH-1:0] r_mem [WORDS];

    function automatic logic [WIDTH-1:0] expected_word(input int unsigned i);
        return (i % 2 == 1) ? ~PATTERN : PATTERN;
    endfunction

    always_comb begin
        w_diff = r_mem[r_idx] ^ expected_word(32'(r_idx));
        w_pop  = '0;
        for (int unsigned b = 0; b < WIDTH; b++) begin
            w_pop = w_pop + PW'(w_diff[b]);
        end
        w_inj_mask = '0;
        for (int unsigned b = 0; b < WIDTH; b++) begin
            if (32'(inject_bit) == b) begin
                w_inj_mask[b] = 1'b1;
            end
        end
        // Additions run one bit wider so the carry selects the clamp value.
        w_flip_sum = {1'b0, flip_count} + (CNT_W + 1)'(event_bits);
        w_evt_sum  = {1'b0, event_count} + 1'b1;
        w_flip_sat = w_flip_sum[CNT_W] ? '1 : w_flip_sum[CNT_W-1:0];
        w_evt_sat  = w_evt_sum[CNT_W]  ? '1 : w_evt_sum[CNT_W-1:0];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_gap_nxt   = r_gap;
        w_advance   = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE:  if (enable) w_state_nxt = S_CHECK;
            S_CHECK: begin
                if (w_diff != '0) w_state_nxt = S_SCRUB;
                else              w_advance   = 1'b1;
            end
            S_SCRUB: w_advance = 1'b1;
            S_GAP: begin
                if (32'(r_gap) == SCAN_GAP - 1) begin
                    w_gap_nxt   = '0;
                    w_state_nxt = enable ? S_CHECK : S_IDLE;
                end else begin
                    w_gap_nxt = r_gap + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_advance) begin
            if (32'(r_idx) == WORDS - 1) begin
                w_done_nxt = 1'b1;
                w_idx_nxt  = '0;
                if (SCAN_GAP == 0) w_state_nxt = enable ? S_CHECK : S_IDLE;
                else               w_state_nxt = S_GAP;
            end else begin
                w_idx_nxt   = r_idx + 1'b1;
                w_state_nxt = enable ? S_CHECK : S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_gap       <= '0;
            error       <= 1'b0;
            flip_count  <= '0;
            event_count <= '0;
            event_valid <= 1'b0;
            event_word  <= '0;
            event_bits  <= '0;
            scan_done   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_gap       <= w_gap_nxt;
            scan_done   <= w_done_nxt;
            event_valid <= (r_state == S_CHECK) && (w_diff != '0);
            // event_bits doubles as the captured popcount consumed in SCRUB.
            if ((r_state == S_CHECK) && (w_diff != '0)) begin
                event_word <= r_idx;
                event_bits <= w_pop;
            end
            if (clear) begin
                error       <= 1'b0;
                flip_count  <= '0;
                event_count <= '0;
            end else if (r_state == S_SCRUB) begin
                error       <= 1'b1;
                flip_count  <= w_flip_sat;
                event_count <= w_evt_sat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < WORDS; i++) begin
                r_mem[i] <= expected_word(i);
            end
        end else begin
            for (int unsigned i = 0; i < WORDS; i++) begin
                if ((r_state == S_SCRUB) && (32'(r_idx) == i)) begin
                    r_mem[i] <= expected_word(i);
                end else if (inject_valid && (32'(inject_word) == i)) begin
                    r_mem[i] <= r_mem[i] ^ w_inj_mask;
                end
            end
        end
    end

endmodule

// File: tb/tb_bitflip_scrub_sensor.sv
// Self-checking bench for bitflip_scrub_sensor: table vectors, directed corner
// sequences and randomized traffic checked against a cycle-level reference model.
module tb_bitflip_scrub_sensor;

    localparam int WORDS    = 16;
    localparam int WIDTH    = 8;
    localparam int CNT_W    = 5;
    localparam int SCAN_GAP = 4;
    localparam int MAXC     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic             clear = 1'b0;
    logic             inject_valid = 1'b0;
    logic [3:0]       inject_word = '0;
    logic [2:0]       inject_bit = '0;
    logic             error;
    logic [CNT_W-1:0] flip_count;
    logic [CNT_W-1:0] event_count;
    logic             event_valid;
    logic [3:0]       event_word;
    logic [3:0]       event_bits;
    logic             scan_done;

    int n_cmp = 0;
    int n_bad = 0;

    bitflip_scrub_sensor #(
        .WORDS(WORDS), .WIDTH(WIDTH), .PATTERN(8'hA5), .CNT_W(CNT_W), .SCAN_GAP(SCAN_GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
        .inject_valid(inject_valid), .inject_word(inject_word), .inject_bit(inject_bit),
        .error(error), .flip_count(flip_count), .event_count(event_count),
        .event_valid(event_valid), .event_word(event_word), .event_bits(event_bits),
        .scan_done(scan_done)
    );

    always #5 clk = ~clk;

    // Reference model: words as plain ints, scan position and remaining-rest counter.
    int m_mem[WORDS];
    int m_idx, m_rest;
    bit m_looking, m_fixing;
    int m_flips, m_events, m_err, m_ev, m_ev_word, m_ev_bits, m_done;

    function automatic int expw(input int i);
        return (i % 2 == 1) ? 'h5A : 'hA5;
    endfunction

    function automatic int popcount(input int v);
        int c = 0;
        for (int b = 0; b < WIDTH; b++) c += (v >> b) & 1;
        return c;
    endfunction

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < WORDS; i++) m_mem[i] = expw(i);
        m_idx = 0; m_rest = 0; m_looking = 0; m_fixing = 0;
        m_flips = 0; m_events = 0; m_err = 0;
        m_ev = 0; m_ev_word = 0; m_ev_bits = 0; m_done = 0;
    endtask

    task automatic model_step(input bit en, input bit clr, input bit iv, input int iw, input int ib);
        bit adv, was_fix;
        int fix_at, d;
        adv = 0; was_fix = m_fixing; fix_at = m_idx;
        m_ev = 0; m_done = 0;
        if (m_fixing) begin
            m_mem[m_idx] = expw(m_idx);
            if (!clr) begin
                m_flips = sat(m_flips + m_ev_bits);
                m_events = sat(m_events + 1);
                m_err = 1;
            end
            m_fixing = 0; adv = 1;
        end else if (m_looking) begin
            d = popcount(m_mem[m_idx] ^ expw(m_idx));
            if (d != 0) begin
                m_looking = 0; m_fixing = 1;
                m_ev = 1; m_ev_word = m_idx; m_ev_bits = d;
            end else adv = 1;
        end else if (m_rest > 0) begin
            m_rest--;
            if (m_rest == 0) m_looking = en;
        end else m_looking = en;
        if (clr) begin m_flips = 0; m_events = 0; m_err = 0; end
        if (adv) begin
            m_looking = 0;
            if (m_idx == WORDS - 1) begin
                m_done = 1; m_idx = 0;
                if (SCAN_GAP == 0) m_looking = en; else m_rest = SCAN_GAP;
            end else begin
                m_idx++; m_looking = en;
            end
        end
        if (iv && iw < WORDS && ib < WIDTH && !(was_fix && iw == fix_at))
            m_mem[iw] ^= (1 << ib);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step(enable, clear, inject_valid, int'(inject_word), int'(inject_bit));
        #1;
        chk("error", int'(error), m_err);
        chk("flip_count", int'(flip_count), m_flips);
        chk("event_count", int'(event_count), m_events);
        chk("event_valid", int'(event_valid), m_ev);
        chk("event_word", int'(event_word), m_ev_word);
        chk("event_bits", int'(event_bits), m_ev_bits);
        chk("scan_done", int'(scan_done), m_done);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b0; clear = 1'b0; inject_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic inject(input int w, input int b);
        inject_valid = 1'b1; inject_word = 4'(w); inject_bit = 3'(b);
        tick();
        inject_valid = 1'b0;
    endtask

    task automatic run_to_done(input int limit, output int cycles, output int evs);
        cycles = 0; evs = 0;
        do begin
            tick(); cycles++;
            if (event_valid) evs++;
        end while (!scan_done && cycles < limit);
        if (!scan_done) chk("scan_done_timeout", int'(scan_done), 1);
    endtask

    typedef struct {
        int word; int nb; int b0; int b1; int b2;
        int exp_evs; int exp_bits; int exp_cycles; int exp_read;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int cyc, evs, got_w, got_b, last, bl[3];

        tbl[0] = '{5,  1, 3, 0, 0, 1, 1, 18, 'h5A};
        tbl[1] = '{2,  3, 0, 2, 7, 1, 3, 18, 'hA5};
        tbl[2] = '{3,  2, 1, 1, 0, 0, 0, 17, 'h5A};
        tbl[3] = '{15, 1, 0, 0, 0, 1, 1, 18, 'h5A};
        tbl[4] = '{0,  3, 7, 6, 5, 1, 3, 18, 'hA5};
        tbl[5] = '{8,  2, 4, 6, 0, 1, 2, 18, 'hA5};

        model_reset();
        do_reset();

        // Clean passes: first scan_done 17 ticks after enable, then every 20.
        enable = 1'b1;
        run_to_done(40, cyc, evs);
        chk("clean_first_pass_cycles", cyc, 17);
        chk("clean_pass_events", evs, 0);
        for (int p = 0; p < 2; p++) begin
            run_to_done(40, cyc, evs);
            chk("clean_pass_period", cyc, 20);
            chk("clean_pass_events", evs, 0);
        end
        chk("clean_error", int'(error), 0);
        chk("clean_flip_count", int'(flip_count), 0);

        // Table vectors: inject while idle, then run one pass.
        for (int t = 0; t < 6; t++) begin
            do_reset();
            bl[0] = tbl[t].b0; bl[1] = tbl[t].b1; bl[2] = tbl[t].b2;
            for (int k = 0; k < tbl[t].nb; k++) inject(tbl[t].word, bl[k]);
            enable = 1'b1;
            cyc = 0; evs = 0; got_w = -1; got_b = -1;
            do begin
                tick(); cyc++;
                if (event_valid) begin evs++; got_w = int'(event_word); got_b = int'(event_bits); end
            end while (!scan_done && cyc < 40);
            chk("vec_pass_cycles", cyc, tbl[t].exp_cycles);
            chk("vec_event_pulses", evs, tbl[t].exp_evs);
            if (tbl[t].exp_evs > 0) begin
                chk("vec_event_word", got_w, tbl[t].word);
                chk("vec_event_bits", got_b, tbl[t].exp_bits);
            end
            chk("vec_flip_count", int'(flip_count), tbl[t].exp_bits);
            chk("vec_event_count", int'(event_count), tbl[t].exp_evs);
            chk("vec_error", int'(error), tbl[t].exp_evs);
            chk("vec_readback", int'(dut.r_mem[tbl[t].word]), tbl[t].exp_read);
        end

        // Saturation: reach MAX-1 flips, then a 3-bit error clamps at MAX.
        do_reset();
        for (int w = 0; w < 3; w++) for (int b = 0; b < 8; b++) inject(w, b);
        for (int b = 0; b < 6; b++) inject(3, b);
        enable = 1'b1;
        run_to_done(60, cyc, evs);
        chk("sat_pre_flip", int'(flip_count), MAXC - 1);
        chk("sat_pre_events", int'(event_count), 4);
        for (int b = 0; b < 3; b++) inject(4, b);
        run_to_done(60, cyc, evs);
        chk("sat_flip", int'(flip_count), MAXC);
        chk("sat_events", int'(event_count), 5);
        chk("sat_error", int'(error), 1);

        // clear coinciding with a SCRUB wins; the pulse still appears once.
        do_reset();
        inject(1, 0);
        inject(6, 0);
        enable = 1'b1;
        cyc = 0; evs = 0;
        do begin
            tick(); cyc++;
            clear = 1'b0;
            if (event_valid) begin
                evs++;
                if (event_word == 4'd6) begin
                    chk("clr_pre_flip", int'(flip_count), 1);
                    clear = 1'b1;
                end
            end
        end while (!scan_done && cyc < 40);
        clear = 1'b0;
        chk("clr_event_pulses", evs, 2);
        chk("clr_flip", int'(flip_count), 0);
        chk("clr_events", int'(event_count), 0);
        chk("clr_error", int'(error), 0);

        // Enable drop after CHECK of word 3: idle retains idx, resume reaches word 9.
        do_reset();
        inject(9, 0);
        enable = 1'b1;
        repeat (4) tick();
        enable = 1'b0;
        evs = 0; last = 0;
        repeat (10) begin
            tick();
            evs += int'(event_valid);
            last += int'(scan_done);
        end
        chk("idle_no_events", evs, 0);
        chk("idle_no_scan_done", last, 0);
        enable = 1'b1;
        cyc = 0;
        do begin tick(); cyc++; end while (!event_valid && cyc < 30);
        chk("resume_event_delay", cyc, 7);
        chk("resume_event_word", int'(event_word), 9);
        repeat (3) tick();
        inject(10, 2);

        // Asynchronous reset mid-pass clears outputs and restores the array at once.
        rst_n = 1'b0;
        #1;
        chk("rst_error", int'(error), 0);
        chk("rst_flip", int'(flip_count), 0);
        chk("rst_events", int'(event_count), 0);
        chk("rst_event_valid", int'(event_valid), 0);
        chk("rst_event_word", int'(event_word), 0);
        chk("rst_event_bits", int'(event_bits), 0);
        chk("rst_scan_done", int'(scan_done), 0);
        chk("rst_array_restored", int'(dut.r_mem[10]), 'hA5);
        model_reset();
        tick();
        rst_n = 1'b1;

        // Randomized traffic against the model.
        enable = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            enable = ($urandom_range(0, 99) < 93);
            clear = ($urandom_range(0, 99) < 2);
            inject_valid = ($urandom_range(0, 99) < 12);
            inject_word = 4'($urandom_range(0, WORDS - 1));
            inject_bit = 3'($urandom_range(0, WIDTH - 1));
            tick();
        end
        inject_valid = 1'b0; clear = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
